riscvboy_mem_arb: RTL and testbench
===================================

// Module: riscvboy_mem_arb
// PURPOSE
//  Shares one single-port memory bus between the IFU instruction-read port and the MACC data port.
//  Sits between the core and unified RAM; the core sees two independent req/gnt/rvalid ports.
//  Data has priority; a starvation counter guarantees forward progress for fetch.
//  At most one read outstanding on the bus; responses are routed back to the issuing port.
// PARAMETERS
//  ADDR_W      32  address width, both ports and bus
//  DATA_W      32  data width; byte enables are DATA_W/8
//  STARVE_MAX  4   consecutive fetch denials before fetch is forced to win (1..15)
// PORTS
//  clk_sys       in   1         system clock
//  rst_sys       in   1         synchronous, active-high reset
//  i_if_req      in   1         fetch read request
//  i_if_addr     in   ADDR_W    fetch address
//  o_if_gnt      out  1         fetch request accepted this cycle
//  o_if_rvalid   out  1         fetch read data valid
//  o_if_rdata    out  DATA_W    fetch read data
//  i_d_req       in   1         data request
//  i_d_we        in   1         1=write, 0=read
//  i_d_wbe       in   DATA_W/8  write byte enables
//  i_d_addr      in   ADDR_W    data address
//  i_d_wdata     in   DATA_W    write data
//  o_d_gnt       out  1         data request accepted this cycle
//  o_d_rvalid    out  1         data read data valid (reads only)
//  o_d_rdata     out  DATA_W    data read data
//  o_bus_req     out  1         bus request
//  o_bus_we      out  1         bus write
//  o_bus_wbe     out  DATA_W/8  bus byte enables (all-ones on reads)
//  o_bus_addr    out  ADDR_W    bus address
//  o_bus_wdata   out  DATA_W    bus write data
//  i_bus_gnt     in   1         bus accepted request
//  i_bus_rvalid  in   1         bus read response valid
//  i_bus_rdata   in   DATA_W    bus read data
//  o_err         out  1         sticky: rvalid seen with no read outstanding
// BEHAVIOUR
//  Reset: state IDLE, starve cnt 0, o_err 0, all gnt/rvalid/bus_req 0; bus addr/data/wbe 0.
//  States: IDLE (no read outstanding), RD_I (fetch read outstanding), RD_D (data read outstanding).
//  Issue is allowed in IDLE, or in RD_* in the same cycle i_bus_rvalid=1 (back-to-back).
//  Selection when issue allowed: data if i_d_req && !(i_if_req && cnt==STARVE_MAX); else fetch if i_if_req.
//  Bus signals are combinational from the selected port; o_bus_req = issue_allowed && (i_if_req||i_d_req).
//  o_x_gnt = selected && i_bus_gnt (same cycle). No request is held internally; requesters must hold until gnt.
//  Data write granted -> next state IDLE; no response is generated. Read granted -> RD_I / RD_D.
//  Response: in RD_I, i_bus_rvalid -> o_if_rvalid=1, o_if_rdata=i_bus_rdata (combinational, 0-cycle); RD_D likewise.
//  Inactive rdata output is held at 0. rvalid with no new grant -> IDLE.
//  Starve cnt: +1 (saturating at STARVE_MAX) on each cycle i_if_req=1 and fetch not granted;
//   cleared on fetch grant or when i_if_req=0.
//  Bus gnt=0 while request is presented: no state change, cnt still counts a fetch denial.
//  i_bus_rvalid in IDLE: ignored for routing, o_err set (cleared only by reset).
//  Reset mid-read: outstanding read dropped; a later stray rvalid sets o_err.
// STRUCTURE
//  riscvboy_pkg: state encoding localparams (ARB_IDLE/ARB_RD_I/ARB_RD_D), owner codes.
//  Sub-module arb_starve_ctr: saturating denial counter (inc, clr, sat flag).
//  Remainder is a single-module FSM plus output muxes.
// TESTING
//  Fetch only: if_req addr 0x100, gnt=1, rvalid next cycle rdata 0x13 -> if_gnt, if_rvalid+0x13, back to IDLE.
//  Conflict: both req same cycle, d_we=0 -> d_gnt=1, if_gnt=0; cnt=1; data rvalid routes only to o_d_*.
//  Starvation: both req held, every read responds in 1 cycle -> fetch granted on 5th issue (cnt hit 4), cnt cleared.
//  Write: d_req we=1 wbe=4'b0011 addr 0x200 wdata 0xABCD -> bus mirrors fields, d_gnt, no d_rvalid, IDLE.
//  Back-to-back: in RD_I with rvalid=1 and d_req read -> if_rvalid and d_gnt same cycle, state RD_D.
//  Stray/reset: assert rst_sys while RD_D, then rvalid -> no d_rvalid, o_err=1 until next reset.

Source files
------------

// File: rtl/riscvboy_mem_arb_pkg.sv
// Shared definitions for the riscvboy memory arbiter.
// Contents:
//   *_DEF        default widths and the starvation limit
//   CNT_W        width of the fetch-denial counter (limit range 1..15)
//   arb_state_t  arbiter FSM state: idle or which port owns the outstanding read
//   owner_t      which port is being presented to the bus this cycle
package riscvboy_mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,  // no read outstanding
        ARB_RD_I = 2'd1,  // fetch read outstanding
        ARB_RD_D = 2'd2   // data read outstanding
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/riscvboy_mem_arb_if.sv
// Signal bundle for the arbiter: fetch port, data port and shared bus.
// Modports:
//   slave  - the arbiter: takes requests from both core ports and bus
//            responses, drives grants/responses to the core and the bus request.
//   master - the surrounding core and memory that talk to the arbiter.
// Handshake: a core port holds req (and its fields) until gnt is seen high in
// the same cycle; gnt means the bus accepted it. rvalid is a one-cycle pulse
// carrying rdata; it has no back-pressure. rdata is 0 whenever rvalid is 0.
interface riscvboy_mem_arb_if
    import riscvboy_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    // data port
    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_wbe;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [DATA_W-1:0]   d_rdata;
    // shared memory bus
    logic                bus_req;
    logic                bus_we;
    logic [DATA_W/8-1:0] bus_wbe;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_gnt;
    logic                bus_rvalid;
    logic [DATA_W-1:0]   bus_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_wbe, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output bus_req, bus_we, bus_wbe, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_wbe, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  bus_req, bus_we, bus_wbe, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/riscvboy_mem_arb_starve_ctr.sv
// Saturating counter of consecutive cycles in which fetch wanted the bus but
// was not granted.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   inc       count one more denial (holds once saturated)
//   clr       clear to zero (wins over inc)
//   cnt       current count
//   sat       count has reached MAX; fetch must win the next issue slot
module riscvboy_mem_arb_starve_ctr
    import riscvboy_mem_arb_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    assign sat = (cnt == MAX_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/riscvboy_mem_arb.sv
// Shares one single-port memory bus between the fetch (read-only) port and the
// data port. Data wins by default; after STARVE_MAX consecutive fetch denials
// fetch is forced through. At most one read is outstanding; its response is
// routed combinationally back to the port that issued it.
// Ports:
//   clk_sys, rst_sys  clock, synchronous active-high reset
//   bus               fetch/data/bus signal bundle (slave side)
//   err               sticky: bus rvalid arrived with no read outstanding
//   state             current FSM state (debug)
//   starve_cnt        current fetch-denial count (debug)
module riscvboy_mem_arb
    import riscvboy_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                   clk_sys,
    input  logic                   rst_sys,
    riscvboy_mem_arb_if.slave      bus,
    output logic                   err,
    output arb_state_t             state,
    output logic [CNT_W-1:0]       starve_cnt
);
    localparam int BE_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    owner_t            sel;
    logic              issue_ok;
    logic              starve_sat;
    logic              if_gnt_w, d_gnt_w;
    logic              if_rvalid_w, d_rvalid_w;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [BE_W-1:0]   wbe_mux;
    logic              we_mux;

    // A new request may go out when idle, or in the very cycle the
    // outstanding read completes (back-to-back issue).
    always_comb begin
        issue_ok = (state_q == ARB_IDLE) || bus.bus_rvalid;
        sel      = OWN_NONE;
        if (issue_ok) begin
            if (bus.d_req && !(bus.if_req && starve_sat)) begin
                sel = OWN_D;
            end else if (bus.if_req) begin
                sel = OWN_IF;
            end
        end
    end

    // Bus fields follow the selected port; reads always carry all byte lanes.
    always_comb begin
        we_mux    = 1'b0;
        wbe_mux   = '0;
        addr_mux  = '0;
        wdata_mux = '0;
        case (sel)
            OWN_D: begin
                we_mux    = bus.d_we;
                wbe_mux   = bus.d_we ? bus.d_wbe : '1;
                addr_mux  = bus.d_addr;
                wdata_mux = bus.d_wdata;
            end
            OWN_IF: begin
                wbe_mux  = '1;
                addr_mux = bus.if_addr;
            end
            default: ;
        endcase
    end

    assign bus.bus_req   = (sel != OWN_NONE);
    assign bus.bus_we    = we_mux;
    assign bus.bus_wbe   = wbe_mux;
    assign bus.bus_addr  = addr_mux;
    assign bus.bus_wdata = wdata_mux;

    assign if_gnt_w = (sel == OWN_IF) && bus.bus_gnt;
    assign d_gnt_w  = (sel == OWN_D) && bus.bus_gnt;
    assign bus.if_gnt = if_gnt_w;
    assign bus.d_gnt  = d_gnt_w;

    // Response routing by the owner recorded in the state.
    assign if_rvalid_w   = (state_q == ARB_RD_I) && bus.bus_rvalid;
    assign d_rvalid_w    = (state_q == ARB_RD_D) && bus.bus_rvalid;
    assign bus.if_rvalid = if_rvalid_w;
    assign bus.d_rvalid  = d_rvalid_w;
    assign bus.if_rdata  = if_rvalid_w ? bus.bus_rdata : '0;
    assign bus.d_rdata   = d_rvalid_w ? bus.bus_rdata : '0;

    // A new grant overrides the return to idle after a completing read.
    always_comb begin
        state_d = state_q;
        if ((state_q != ARB_IDLE) && bus.bus_rvalid) begin
            state_d = ARB_IDLE;
        end
        if (d_gnt_w) begin
            state_d = bus.d_we ? ARB_IDLE : ARB_RD_D;
        end else if (if_gnt_w) begin
            state_d = ARB_RD_I;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            err <= 1'b0;
        end else if ((state_q == ARB_IDLE) && bus.bus_rvalid) begin
            err <= 1'b1;
        end
    end

    // Any cycle fetch asks and is not granted (lost arbitration, blocked by
    // an outstanding read, or bus gnt low) counts as a denial.
    riscvboy_mem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk_sys),
        .rst (rst_sys),
        .inc (bus.if_req && !if_gnt_w),
        .clr (!bus.if_req || if_gnt_w),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    assign state = state_q;

endmodule

// File: tb/tb_riscvboy_mem_arb.sv
module tb_riscvboy_mem_arb;
    import riscvboy_mem_arb_pkg::*;

    logic       clk_sys;
    logic       rst_sys;
    logic       err;
    arb_state_t dut_state;
    logic [3:0] starve_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    riscvboy_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    riscvboy_mem_arb #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_sys    (rst_sys),
        .bus        (bus_if),
        .err        (err),
        .state      (dut_state),
        .starve_cnt (starve_cnt)
    );

    // clock
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       name;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_wbe;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        bus_gnt;
        logic        bus_rvalid;
        logic [31:0] bus_rdata;
        logic [1:0]  e_st;
        logic [3:0]  e_cnt;
        logic        e_if_gnt;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_d_gnt;
        logic        e_d_rvalid;
        logic [31:0] e_d_rdata;
        logic        e_bus_req;
        logic        e_bus_we;
        logic [3:0]  e_bus_wbe;
        logic [31:0] e_bus_addr;
        logic [31:0] e_bus_wdata;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(
        input string nm,
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
        input logic bg, input logic bv, input logic [31:0] brd,
        input logic [1:0] st, input logic [3:0] cnt,
        input logic ig, input logic iv, input logic [31:0] ird,
        input logic dg, input logic dv, input logic [31:0] drd,
        input logic br, input logic bw, input logic [3:0] bbe, input logic [31:0] ba, input logic [31:0] bwd,
        input logic er);
        vec_t v;
        v.name = nm;
        v.if_req = ir; v.if_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_wbe = dbe; v.d_addr = da; v.d_wdata = dwd;
        v.bus_gnt = bg; v.bus_rvalid = bv; v.bus_rdata = brd;
        v.e_st = st; v.e_cnt = cnt;
        v.e_if_gnt = ig; v.e_if_rvalid = iv; v.e_if_rdata = ird;
        v.e_d_gnt = dg; v.e_d_rvalid = dv; v.e_d_rdata = drd;
        v.e_bus_req = br; v.e_bus_we = bw; v.e_bus_wbe = bbe; v.e_bus_addr = ba; v.e_bus_wdata = bwd;
        v.e_err = er;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        bus_if.if_req     = 1'b0;
        bus_if.if_addr    = '0;
        bus_if.d_req      = 1'b0;
        bus_if.d_we       = 1'b0;
        bus_if.d_wbe      = '0;
        bus_if.d_addr     = '0;
        bus_if.d_wdata    = '0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus_if.if_req     = v.if_req;
        bus_if.if_addr    = v.if_addr;
        bus_if.d_req      = v.d_req;
        bus_if.d_we       = v.d_we;
        bus_if.d_wbe      = v.d_wbe;
        bus_if.d_addr     = v.d_addr;
        bus_if.d_wdata    = v.d_wdata;
        bus_if.bus_gnt    = v.bus_gnt;
        bus_if.bus_rvalid = v.bus_rvalid;
        bus_if.bus_rdata  = v.bus_rdata;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_sys = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 rst_sys = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        rst_sys = 1'b1;
        idle_inputs();

        //   name              ifreq ifaddr       dreq we wbe  daddr       dwdata        gnt rv rdata          st cnt ig iv irdata        dg dv drdata        br bw bwbe  baddr       bwdata        err
        add("reset_idle",      0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 0, 32'h0,     0, 0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("if_issue",        1, 32'h100,    0, 0, 4'h0, 32'h0,   32'h0,      1, 0, 32'h0,     0, 0,  1, 0, 32'h0,    0, 0, 32'h0,    1, 0, 4'hF, 32'h100, 32'h0,      0);
        add("if_resp",         0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 1, 32'h13,    1, 0,  0, 1, 32'h13,   0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("idle_after_if",   0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 0, 32'h0,     0, 0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("conflict",        1, 32'h104,    1, 0, 4'h5, 32'h300, 32'h0,      1, 0, 32'h0,     0, 0,  0, 0, 32'h0,    1, 0, 32'h0,    1, 0, 4'hF, 32'h300, 32'h0,      0);
        add("conflict_resp",   1, 32'h104,    0, 0, 4'h0, 32'h0,   32'h0,      0, 1, 32'hDEAD,  2, 1,  0, 0, 32'h0,    0, 1, 32'hDEAD, 1, 0, 4'hF, 32'h104, 32'h0,      0);
        add("gnt_low_hold",    1, 32'h104,    0, 0, 4'h0, 32'h0,   32'h0,      0, 0, 32'h0,     0, 2,  0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 4'hF, 32'h104, 32'h0,      0);
        add("if_after_wait",   1, 32'h104,    0, 0, 4'h0, 32'h0,   32'h0,      1, 0, 32'h0,     0, 3,  1, 0, 32'h0,    0, 0, 32'h0,    1, 0, 4'hF, 32'h104, 32'h0,      0);
        add("b2b",             0, 32'h0,      1, 0, 4'h0, 32'h400, 32'h0,      1, 1, 32'h77,    1, 0,  0, 1, 32'h77,   1, 0, 32'h0,    1, 0, 4'hF, 32'h400, 32'h0,      0);
        add("b2b_resp",        0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 1, 32'h88,    2, 0,  0, 0, 32'h0,    0, 1, 32'h88,   0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("write",           0, 32'h0,      1, 1, 4'h3, 32'h200, 32'hABCD,   1, 0, 32'h0,     0, 0,  0, 0, 32'h0,    1, 0, 32'h0,    1, 1, 4'h3, 32'h200, 32'hABCD,   0);
        add("after_write",     0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 0, 32'h0,     0, 0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("d_read",          0, 32'h0,      1, 0, 4'h0, 32'h500, 32'h0,      1, 0, 32'h0,     0, 0,  0, 0, 32'h0,    1, 0, 32'h0,    1, 0, 4'hF, 32'h500, 32'h0,      0);
        add("rd_blocks_issue", 1, 32'h108,    0, 0, 4'h0, 32'h0,   32'h0,      1, 0, 32'h0,     2, 0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("rd_resp_issue",   1, 32'h108,    0, 0, 4'h0, 32'h0,   32'h0,      1, 1, 32'h99,    2, 1,  1, 0, 32'h0,    0, 1, 32'h99,   1, 0, 4'hF, 32'h108, 32'h0,      0);
        add("if_resp2",        0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 1, 32'h5A,    1, 0,  0, 1, 32'h5A,   0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("stray",           0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 1, 32'h66,    0, 0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      0);
        add("err_sticky",      0, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,      0, 0, 32'h0,     0, 0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 4'h0, 32'h0,   32'h0,      1);
        add("err_sticky2",     1, 32'h10C,    0, 0, 4'h0, 32'h0,   32'h0,      1, 0, 32'h0,     0, 0,  1, 0, 32'h0,    0, 0, 32'h0,    1, 0, 4'hF, 32'h10C, 32'h0,      1);

        do_reset();

        // table-driven vectors: inputs applied after a rising edge, outputs
        // and pre-edge state sampled on the falling edge
        foreach (vq[i]) begin
            drive_vec(vq[i]);
            @(negedge clk_sys);
            check({vq[i].name, ".state"},      32'(dut_state),          32'(vq[i].e_st));
            check({vq[i].name, ".cnt"},        32'(starve_cnt),         32'(vq[i].e_cnt));
            check({vq[i].name, ".if_gnt"},     32'(bus_if.if_gnt),      32'(vq[i].e_if_gnt));
            check({vq[i].name, ".if_rvalid"},  32'(bus_if.if_rvalid),   32'(vq[i].e_if_rvalid));
            check({vq[i].name, ".if_rdata"},   bus_if.if_rdata,         vq[i].e_if_rdata);
            check({vq[i].name, ".d_gnt"},      32'(bus_if.d_gnt),       32'(vq[i].e_d_gnt));
            check({vq[i].name, ".d_rvalid"},   32'(bus_if.d_rvalid),    32'(vq[i].e_d_rvalid));
            check({vq[i].name, ".d_rdata"},    bus_if.d_rdata,          vq[i].e_d_rdata);
            check({vq[i].name, ".bus_req"},    32'(bus_if.bus_req),     32'(vq[i].e_bus_req));
            check({vq[i].name, ".bus_we"},     32'(bus_if.bus_we),      32'(vq[i].e_bus_we));
            check({vq[i].name, ".bus_wbe"},    32'(bus_if.bus_wbe),     32'(vq[i].e_bus_wbe));
            check({vq[i].name, ".bus_addr"},   bus_if.bus_addr,         vq[i].e_bus_addr);
            check({vq[i].name, ".bus_wdata"},  bus_if.bus_wdata,        vq[i].e_bus_wdata);
            check({vq[i].name, ".err"},        32'(err),                32'(vq[i].e_err));
            next_cycle();
        end

        // starvation: both ports hold read requests, every read answers in
        // one cycle; fetch must win the fifth issue
        do_reset();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h1000;
        bus_if.d_req   = 1'b1;
        bus_if.d_addr  = 32'h2000;
        bus_if.bus_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus_if.bus_rvalid = (k > 0);
            bus_if.bus_rdata  = (k > 0) ? 32'hA000 + 32'(k) : 32'h0;
            if (k > 0) exp_q.push_back(32'hA000 + 32'(k));
            @(negedge clk_sys);
            check($sformatf("starve%0d.cnt", k),    32'(starve_cnt),     32'(k));
            check($sformatf("starve%0d.d_gnt", k),  32'(bus_if.d_gnt),   (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("starve%0d.if_gnt", k), 32'(bus_if.if_gnt),  (k == 4) ? 32'd1 : 32'd0);
            if (k > 0) begin
                check($sformatf("starve%0d.d_rvalid", k), 32'(bus_if.d_rvalid), 32'd1);
                if (exp_q.size() > 0) check($sformatf("starve%0d.d_rdata", k), bus_if.d_rdata, exp_q.pop_front());
            end
            next_cycle();
        end
        idle_inputs();
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'hB000;
        exp_q.push_back(32'hB000);
        @(negedge clk_sys);
        check("starve_end.state", 32'(dut_state), 32'(ARB_RD_I));
        check("starve_end.cnt", 32'(starve_cnt), 32'd0);
        check("starve_end.if_rvalid", 32'(bus_if.if_rvalid), 32'd1);
        check("starve_end.d_rvalid", 32'(bus_if.d_rvalid), 32'd0);
        if (exp_q.size() > 0) check("starve_end.if_rdata", bus_if.if_rdata, exp_q.pop_front());
        check("starve_end.q_empty", 32'(exp_q.size()), 32'd0);
        next_cycle();

        // saturation: fetch denied by bus gnt low, count stops at the limit
        // and clears once fetch stops asking
        do_reset();
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h3000;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_sys);
            check($sformatf("sat%0d.cnt", k), 32'(starve_cnt), (k < 4) ? 32'(k) : 32'd4);
            check($sformatf("sat%0d.bus_req", k), 32'(bus_if.bus_req), 32'd1);
            next_cycle();
        end
        bus_if.if_req = 1'b0;
        next_cycle();
        @(negedge clk_sys);
        check("sat_clear.cnt", 32'(starve_cnt), 32'd0);
        next_cycle();

        // reset during an outstanding data read: the late response is stray
        do_reset();
        bus_if.d_req   = 1'b1;
        bus_if.d_addr  = 32'h600;
        bus_if.bus_gnt = 1'b1;
        @(negedge clk_sys);
        check("rst_rd.d_gnt", 32'(bus_if.d_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk_sys);
        check("rst_rd.state", 32'(dut_state), 32'(ARB_RD_D));
        next_cycle();
        rst_sys = 1'b1;
        next_cycle();
        rst_sys = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h77;
        @(negedge clk_sys);
        check("rst_rd.state_after", 32'(dut_state), 32'(ARB_IDLE));
        check("rst_rd.err_before", 32'(err), 32'd0);
        check("rst_rd.d_rvalid", 32'(bus_if.d_rvalid), 32'd0);
        check("rst_rd.d_rdata", bus_if.d_rdata, 32'd0);
        next_cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            check($sformatf("rst_rd.err%0d", k), 32'(err), 32'd1);
            next_cycle();
        end
        do_reset();
        @(negedge clk_sys);
        check("rst_rd.err_cleared", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
